// File: rtl/output_arbiter3.sv
// Three-input round-robin output arbiter with packet locking and a single
// registered output stage that never drops or overwrites an unaccepted flit.
module output_arbiter3 #(
  parameter int DataWidth  = 36,
  parameter bit PacketMode = 1'b1
) (
  input  logic                 i_sclk,
  input  logic                 i_reset,
  input  logic [DataWidth-1:0] i_data1,
  input  logic [DataWidth-1:0] i_data2,
  input  logic [DataWidth-1:0] i_data3,
  input  logic                 i_data_valid1,
  input  logic                 i_data_valid2,
  input  logic                 i_data_valid3,
  output logic                 o_data_ready1,
  output logic                 o_data_ready2,
  output logic                 o_data_ready3,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic [1:0]           o_grant
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_p0, state_nxt;
  logic [1:0]           grant_p0, grant_nxt;
  logic [1:0]           rr_p0, rr_nxt;
  logic [DataWidth-1:0] data_p1;
  logic                 vld_p1;

  logic [2:0]           valid_vec;
  logic [2:0]           ready_vec;
  logic                 load_en;
  logic                 xfer;
  logic                 tail;
  logic [DataWidth-1:0] sel_data;

  // First requester in the order rr, rr+1, rr+2 (wrapping 3->1); 0 if none.
  function automatic logic [1:0] rr_pick(input logic [1:0] rr, input logic [2:0] req);
    logic [1:0] pick;
    logic [1:0] bit_idx;
    int         idx;
    pick = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      idx = int'(rr) + i;
      if (idx > 3) idx = idx - 3;
      bit_idx = 2'(idx - 1);
      if (req[bit_idx]) pick = 2'(idx);
    end
    return pick;
  endfunction

  function automatic logic [1:0] rr_after(input logic [1:0] owner);
    return (owner == 2'd3) ? 2'd1 : owner + 2'd1;
  endfunction

  assign valid_vec = {i_data_valid3, i_data_valid2, i_data_valid1};
  assign load_en   = !vld_p1 || i_data_ready;

  assign o_data_ready1 = (grant_p0 == 2'd1) && load_en;
  assign o_data_ready2 = (grant_p0 == 2'd2) && load_en;
  assign o_data_ready3 = (grant_p0 == 2'd3) && load_en;
  assign ready_vec     = {o_data_ready3, o_data_ready2, o_data_ready1};

  assign xfer = |(ready_vec & valid_vec);
  assign tail = sel_data[DataWidth-1];

  always_comb begin
    sel_data = '0;
    case (grant_p0)
      2'd1:    sel_data = i_data1;
      2'd2:    sel_data = i_data2;
      2'd3:    sel_data = i_data3;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state_p0;
    grant_nxt = grant_p0;
    rr_nxt    = rr_p0;
    case (state_p0)
      IDLE: begin
        if (|valid_vec) begin
          state_nxt = LOCKED;
          grant_nxt = rr_pick(rr_p0, valid_vec);
        end
      end
      LOCKED: begin
        // The owner keeps the grant through gaps in its own valid.
        if (xfer && (tail || !PacketMode)) begin
          state_nxt = IDLE;
          grant_nxt = 2'd0;
          rr_nxt    = rr_after(grant_p0);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'd0;
      end
    endcase
  end

  // Stage p0: arbitration state
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      state_p0 <= IDLE;
      grant_p0 <= 2'd0;
      rr_p0    <= 2'd1;
    end else begin
      state_p0 <= state_nxt;
      grant_p0 <= grant_nxt;
      rr_p0    <= rr_nxt;
    end
  end

  // Stage p1: output flit register
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load_en) begin
      if (xfer) begin
        data_p1 <= sel_data;
        vld_p1  <= 1'b1;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign o_data       = data_p1;
  assign o_data_valid = vld_p1;
  assign o_grant      = grant_p0;

endmodule

// File: tb/tb_output_arbiter3.sv
// Directed bench for output_arbiter3: a per-cycle behavioural model check on
// two instances (packet mode and flit mode) plus literal expectations.
module tb_output_arbiter3;
  localparam int W = 36;

  typedef struct {
    int           owner;
    int           rr;
    bit           v;
    logic [W-1:0] d;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // packet-mode instance
  logic [W-1:0] d1, d2, d3, o_data;
  logic         v1, v2, v3, r1, r2, r3, o_valid, dready;
  logic [1:0]   o_grant;
  // flit-mode instance
  logic [W-1:0] e1, e2, e3, o_data0;
  logic         u1, u2, u3, s1, s2, s3, o_valid0, dready0;
  logic [1:0]   o_grant0;

  output_arbiter3 #(.DataWidth(W), .PacketMode(1'b1)) dut (
    .i_sclk(clk), .i_reset(rst),
    .i_data1(d1), .i_data2(d2), .i_data3(d3),
    .i_data_valid1(v1), .i_data_valid2(v2), .i_data_valid3(v3),
    .o_data_ready1(r1), .o_data_ready2(r2), .o_data_ready3(r3),
    .o_data(o_data), .o_data_valid(o_valid), .i_data_ready(dready),
    .o_grant(o_grant));

  output_arbiter3 #(.DataWidth(W), .PacketMode(1'b0)) dut0 (
    .i_sclk(clk), .i_reset(rst),
    .i_data1(e1), .i_data2(e2), .i_data3(e3),
    .i_data_valid1(u1), .i_data_valid2(u2), .i_data_valid3(u3),
    .o_data_ready1(s1), .o_data_ready2(s2), .o_data_ready3(s3),
    .o_data(o_data0), .o_data_valid(o_valid0), .i_data_ready(dready0),
    .o_grant(o_grant0));

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q1[$], q2[$], q3[$];
  logic [2:0]   en;
  logic [W-1:0] delivered[$];
  model_t       m, m0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] flit(input bit t, input logic [15:0] val);
    logic [W-1:0] f;
    f = '0;
    f[W-1] = t;
    f[15:0] = val;
    return f;
  endfunction

  // Model: whoever owns the output moves one flit per free output slot;
  // ownership ends on a tail (or every flit in flit mode) and rr passes on.
  function automatic model_t step(input model_t s, input bit pm, input logic [2:0] vin,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, input bit dr);
    model_t       n;
    bit           slot_free;
    int           k;
    logic [W-1:0] din;
    n = s;
    slot_free = !s.v || dr;
    if (s.owner == 0) begin
      if (slot_free) n.v = 1'b0;
      for (int i = 0; i < 3; i++) begin
        k = (s.rr - 1 + i) % 3 + 1;
        if (n.owner == 0 && vin[k-1]) n.owner = k;
      end
    end else if (slot_free) begin
      din = (s.owner == 1) ? a : (s.owner == 2) ? b : c;
      if (vin[s.owner-1]) begin
        n.v = 1'b1;
        n.d = din;
        if (!pm || din[W-1]) begin
          n.owner = 0;
          n.rr = s.owner % 3 + 1;
        end
      end else begin
        n.v = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [2:0] ready_of(input model_t s, input bit dr);
    if (s.owner != 0 && (!s.v || dr)) return 3'(1 << (s.owner - 1));
    return 3'b000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m  <= '{owner: 0, rr: 1, v: 1'b0, d: '0};
      m0 <= '{owner: 0, rr: 1, v: 1'b0, d: '0};
    end else begin
      m  <= step(m, 1'b1, {v3, v2, v1}, d1, d2, d3, dready);
      m0 <= step(m0, 1'b0, {u3, u2, u1}, e1, e2, e3, dready0);
    end
  end

  always @(negedge clk) begin
    check("grant", 64'(o_grant), 64'(m.owner));
    check("ready", 64'({r3, r2, r1}), 64'(ready_of(m, dready)));
    check("valid", 64'(o_valid), 64'(m.v));
    if (m.v) check("data", 64'(o_data), 64'(m.d));
    check("grant0", 64'(o_grant0), 64'(m0.owner));
    check("ready0", 64'({s3, s2, s1}), 64'(ready_of(m0, dready0)));
    check("valid0", 64'(o_valid0), 64'(m0.v));
    if (m0.v) check("data0", 64'(o_data0), 64'(m0.d));
    if (o_valid && dready) delivered.push_back(o_data);
  end

  task automatic drive();
    v1 = en[0] && (q1.size() > 0);
    v2 = en[1] && (q2.size() > 0);
    v3 = en[2] && (q3.size() > 0);
    d1 = (q1.size() > 0) ? q1[0] : '0;
    d2 = (q2.size() > 0) ? q2[0] : '0;
    d3 = (q3.size() > 0) ? q3[0] : '0;
  endtask

  task automatic tick();
    logic [2:0] x;
    @(negedge clk);
    x = {r3 & v3, r2 & v2, r1 & v1};
    @(posedge clk);
    #1;
    if (x[0]) void'(q1.pop_front());
    if (x[1]) void'(q2.pop_front());
    if (x[2]) void'(q3.pop_front());
    drive();
    #1;
  endtask

  task automatic clear_src();
    q1.delete(); q2.delete(); q3.delete();
    en = 3'b000;
    u1 = 1'b0; u2 = 1'b0; u3 = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    dready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_grant", 64'(o_grant), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_ready", 64'({r3, r2, r1}), 64'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int exp_g[8];
    int cnt;
    e1 = '0; e2 = '0; e3 = '0;
    dready0 = 1'b1;
    dready = 1'b1;
    clear_src();

    // single 3-flit packet on requester 2
    do_reset();
    q2.push_back(flit(0, 16'h201)); q2.push_back(flit(0, 16'h202)); q2.push_back(flit(1, 16'h203));
    en = 3'b010; drive(); #1;
    check("A_c0_grant", 64'(o_grant), 64'd0);
    check("A_c0_ready2", 64'(r2), 64'd0);
    tick();
    check("A_c1_grant", 64'(o_grant), 64'd2);
    check("A_c1_ready2", 64'(r2), 64'd1);
    check("A_c1_valid", 64'(o_valid), 64'd0);
    tick();
    check("A_c2_valid", 64'(o_valid), 64'd1);
    check("A_c2_data", 64'(o_data), 64'(flit(0, 16'h201)));
    tick();
    check("A_c3_ready2", 64'(r2), 64'd1);
    check("A_c3_data", 64'(o_data), 64'(flit(0, 16'h202)));
    tick();
    check("A_c4_grant", 64'(o_grant), 64'd0);
    check("A_c4_data", 64'(o_data), 64'(flit(1, 16'h203)));
    check("A_model_rr", 64'(m.rr), 64'd3);
    tick();
    check("A_c5_valid", 64'(o_valid), 64'd0);

    // contention of three single-flit requesters
    do_reset();
    q1.push_back(flit(1, 16'h11)); q1.push_back(flit(1, 16'h12));
    q2.push_back(flit(1, 16'h21)); q2.push_back(flit(1, 16'h22));
    q3.push_back(flit(1, 16'h31)); q3.push_back(flit(1, 16'h32));
    en = 3'b111; drive(); #1;
    exp_g = '{1, 0, 2, 0, 3, 0, 1, 0};
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("B_grant", 64'(o_grant), 64'(exp_g[c-1]));
      if (c == 1) check("B_losers", 64'({r3, r2}), 64'd0);
      if (c == 2) check("B_data", 64'(o_data), 64'(flit(1, 16'h11)));
      if (c == 4) check("B_data", 64'(o_data), 64'(flit(1, 16'h21)));
      if (c == 6) check("B_data", 64'(o_data), 64'(flit(1, 16'h31)));
      if (c == 8) check("B_data", 64'(o_data), 64'(flit(1, 16'h12)));
    end

    // downstream backpressure for four cycles
    do_reset();
    delivered.delete();
    q1.push_back(flit(0, 16'h101)); q1.push_back(flit(1, 16'h102));
    en = 3'b001; drive(); #1;
    tick();
    check("C_c1_grant", 64'(o_grant), 64'd1);
    tick();
    dready = 1'b0; #1;
    for (int c = 0; c < 4; c++) begin
      check("C_hold_valid", 64'(o_valid), 64'd1);
      check("C_hold_data", 64'(o_data), 64'(flit(0, 16'h101)));
      check("C_hold_ready", 64'({r3, r2, r1}), 64'd0);
      if (c < 3) tick();
    end
    tick();
    dready = 1'b1; #1;
    check("C_resume_ready1", 64'(r1), 64'd1);
    check("C_resume_data", 64'(o_data), 64'(flit(0, 16'h101)));
    tick();
    check("C_next_data", 64'(o_data), 64'(flit(1, 16'h102)));
    tick();
    cnt = 0;
    foreach (delivered[i]) if (delivered[i] == flit(0, 16'h101)) cnt++;
    check("C_once", 64'(cnt), 64'd1);

    // owner gap while requester 3 waits
    do_reset();
    q1.push_back(flit(0, 16'h111)); q1.push_back(flit(0, 16'h112)); q1.push_back(flit(1, 16'h113));
    q3.push_back(flit(1, 16'h301));
    en = 3'b101; drive(); #1;
    tick();
    check("D_c1_grant", 64'(o_grant), 64'd1);
    tick();
    en[0] = 1'b0; drive(); #1;
    for (int c = 0; c < 3; c++) begin
      check("D_gap_grant", 64'(o_grant), 64'd1);
      check("D_gap_ready3", 64'(r3), 64'd0);
      tick();
    end
    en[0] = 1'b1; drive(); #1;
    tick();
    check("D_c6_data", 64'(o_data), 64'(flit(0, 16'h112)));
    tick();
    check("D_c7_grant", 64'(o_grant), 64'd0);
    check("D_c7_data", 64'(o_data), 64'(flit(1, 16'h113)));
    tick();
    check("D_c8_grant", 64'(o_grant), 64'd3);
    tick();
    check("D_c9_data", 64'(o_data), 64'(flit(1, 16'h301)));

    // flit mode interleaving
    do_reset();
    e1 = flit(0, 16'hA1); e2 = flit(0, 16'hA2);
    u1 = 1'b1; u2 = 1'b1; #1;
    exp_g = '{1, 0, 2, 0, 1, 0, 2, 0};
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("E_grant", 64'(o_grant0), 64'(exp_g[c-1]));
      if (c % 2 == 0) begin
        check("E_valid", 64'(o_valid0), 64'd1);
        check("E_data", 64'(o_data0), 64'((c % 4 == 2) ? flit(0, 16'hA1) : flit(0, 16'hA2)));
      end else if (c > 1) begin
        check("E_bubble", 64'(o_valid0), 64'd0);
      end
    end

    // asynchronous reset in the middle of a packet
    do_reset();
    q2.push_back(flit(0, 16'h221)); q2.push_back(flit(0, 16'h222)); q2.push_back(flit(1, 16'h223));
    en = 3'b010; drive(); #1;
    tick();
    check("F_c1_grant", 64'(o_grant), 64'd2);
    tick();
    check("F_c2_valid", 64'(o_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("F_async_grant", 64'(o_grant), 64'd0);
    check("F_async_valid", 64'(o_valid), 64'd0);
    check("F_async_data", 64'(o_data), 64'd0);
    check("F_async_ready", 64'({r3, r2, r1}), 64'd0);
    clear_src();
    q1.push_back(flit(1, 16'h1F)); q2.push_back(flit(1, 16'h2F)); q3.push_back(flit(1, 16'h3F));
    en = 3'b111; drive();
    rst = 1'b0;
    tick();
    check("F_rr_restart", 64'(o_grant), 64'd1);
    tick();
    tick();
    check("F_next_grant", 64'(o_grant), 64'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
